// File: rtl/mem_read_cache.sv
// Direct-mapped read-only cache in front of a slow pulse-request memory.
// Hits answer in one cycle; misses issue a single-cycle memory read.
module mem_read_cache #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_re,
    input  logic [15:0] cpu_addr,
    output logic        cpu_ready,
    output logic [15:0] cpu_data,
    input  logic        flush,
    output logic        mem_re,
    output logic [15:0] mem_addr,
    input  logic        mem_ready,
    input  logic [15:0] mem_data,
    output logic        busy,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);

    localparam int TAG_W = 16 - IDX_W;

    typedef enum logic [0:0] {
        IDLE,
        MISS_WAIT
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tag_mem  [ENTRIES];
    logic [15:0]        data_mem [ENTRIES];

    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] miss_idx;
    logic [TAG_W-1:0] miss_tag;

    logic flush_pend;
    logic flush_eff;
    logic lookup_hit;
    logic do_hit;
    logic do_miss;
    logic do_fill;

    assign req_idx = cpu_addr[IDX_W-1:0];
    assign req_tag = cpu_addr[15:IDX_W];

    // A flush seen during a miss is replayed on the first idle edge.
    assign flush_eff = flush | flush_pend;

    // Lookup sees the post-flush state when flush lands on the same edge.
    assign lookup_hit = valid[req_idx] && !flush_eff &&
                        (tag_mem[req_idx] == req_tag);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:      if (do_miss) state_nxt = MISS_WAIT;
            MISS_WAIT: if (do_fill) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Per-state action strobes; requests during a miss are dropped.
    always_comb begin
        do_hit  = 1'b0;
        do_miss = 1'b0;
        do_fill = 1'b0;
        unique case (state)
            IDLE: begin
                do_hit  = cpu_re && lookup_hit;
                do_miss = cpu_re && !lookup_hit;
            end
            MISS_WAIT: begin
                do_fill = mem_ready;
            end
            default: ;
        endcase
    end

    // Valid bits and the deferred-flush flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid      <= '0;
            flush_pend <= 1'b0;
        end else if (state == IDLE) begin
            flush_pend <= 1'b0;
            if (flush_eff) valid <= '0;
        end else begin
            flush_pend <= flush_pend | flush;
            if (do_fill) valid[miss_idx] <= 1'b1;
        end
    end

    // Tag and data arrays, written only on a fill.
    always_ff @(posedge clk) begin
        if (rst_n && do_fill) begin
            tag_mem[miss_idx]  <= miss_tag;
            data_mem[miss_idx] <= mem_data;
        end
    end

    // Registered outputs, counters and the latched miss line.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cpu_ready  <= 1'b0;
            cpu_data   <= '0;
            mem_re     <= 1'b0;
            mem_addr   <= '0;
            busy       <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
            miss_idx   <= '0;
            miss_tag   <= '0;
        end else begin
            cpu_ready <= 1'b0;
            mem_re    <= 1'b0;
            if (do_hit) begin
                cpu_ready <= 1'b1;
                cpu_data  <= data_mem[req_idx];
                hit_count <= hit_count + 16'd1;
            end
            if (do_miss) begin
                mem_re     <= 1'b1;
                mem_addr   <= cpu_addr;
                busy       <= 1'b1;
                miss_count <= miss_count + 16'd1;
                miss_idx   <= req_idx;
                miss_tag   <= req_tag;
            end
            if (do_fill) begin
                cpu_ready <= 1'b1;
                cpu_data  <= mem_data;
                busy      <= 1'b0;
            end
        end
    end

endmodule
